debug_run_controller: RTL and testbench
=======================================

# debug_run_controller

Sequences the MIPS_DLX pipeline from a host byte stream. In LOAD mode it assembles received bytes into 32-bit words and writes them into instruction memory. In RUN mode it gates the pipeline free-running until a halt instruction retires. In STEP mode it advances the pipeline one clock per host command. It sits between the UART receiver and the pipeline top, driving the pipeline's clock-enable, pipeline reset and instruction-memory write port.

## Interface
- Parameters:
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that ends RUN when it reaches write-back
- ADDR_W, 10, instruction-memory address width (matches 10-bit PC)
- Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- wb_halt  in  1  high when the instruction in write-back equals HALT_WORD (pipeline-supplied)
- pipe_enable  out  1  pipeline clock-enable (all stage registers, PC)
- pipe_reset  out  1  one-cycle pipeline clear (PC to 0, stage registers to 0)
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  write data
- cycle_count  out  32  enabled pipeline cycles since last RUN/STEP entry
- state  out  3  IDLE=0, LD_CNT=1, LD_DATA=2, RUN=3, STEP=4, DONE=5
- done  out  1  high while in DONE

## Operation
- Reset: state=IDLE; pipe_enable=0, pipe_reset=0, imem_we=0, imem_addr=0, imem_wdata=0, cycle_count=0, done=0; byte index and word counter = 0.
- IDLE, rx_valid with:
  - 0x4C 'L' -> LD_CNT.
  - 0x52 'R' -> RUN, pulse pipe_reset, clear cycle_count.
  - 0x53 'S' -> STEP, pulse pipe_reset, clear cycle_count.
  - Any other byte is ignored.
- LD_CNT: the next byte N sets the word count. N=0 means 256 words. imem_addr is set to 0. -> LD_DATA.
- LD_DATA:
  - Bytes arrive MSB first, 4 per word, shifted into imem_wdata.
  - On the 4th byte, imem_we pulses for one cycle with the current imem_addr. imem_addr increments in the following cycle.
  - After the N-th word is written -> IDLE.
  - Address wraps modulo 2^ADDR_W; with N ≤ 256 no wrap occurs.
- RUN:
  - pipe_enable=1 every cycle.
  - On wb_halt=1, go to DONE the next edge. The halt cycle itself counts and is enabled.
  - rx byte 0x51 'Q' forces DONE.
- STEP:
  - pipe_enable=0 by default.
  - rx byte 0x73 's' makes pipe_enable=1 for exactly one cycle.
  - 'Q' -> IDLE.
  - If wb_halt is sampled high during an enabled step -> DONE.
- DONE: pipe_enable=0, done=1, cycle_count held. Any rx byte -> IDLE.
- cycle_count increments on every cycle with pipe_enable=1 and saturates at 32'hFFFF_FFFF.
- Bytes arriving while in RUN (other than 'Q') are dropped. In LD_DATA every byte is data, including 'L', 'R', 'S' and 'Q'.
- reset mid-load: the partial word is discarded. No imem_we is issued on the reset edge or after.

## Timing
- All outputs are registered.
- Latencies, counted from the edge where the byte is sampled:
  - rx_valid of the 4th data byte at edge k -> imem_we high during cycle k+1.
  - 'R' at edge k -> pipe_reset high in cycle k+1, pipe_enable high from cycle k+2.
  - 's' at edge k -> pipe_enable high in cycle k+1 only.
- pipe_reset and pipe_enable are never high in the same cycle.
- wb_halt sampled at edge k in RUN -> pipe_enable low from cycle k+1, done high from cycle k+1.
- Back-to-back rx_valid every cycle must be accepted in all states. No byte is lost.
- Simultaneous 's' and wb_halt in STEP: the halt wins, and the step pulse is not issued.

## Test plan
- Reset with rx_valid active → all outputs 0, state=0, next byte treated in IDLE.
- Load 'L', 0x02, 12 34 56 78 9A BC DE F0 → imem_we at addr 0 with 32'h12345678, then addr 1 with 32'h9ABCDEF0, then state=IDLE, exactly 2 write strobes.
- 'R', wb_halt raised 20 cycles after pipe_enable first rises → one pipe_reset pulse, done=1, cycle_count=21, pipe_enable=0.
- 'S', then three 's' bytes spaced 5 cycles apart, then 'Q' → exactly three 1-cycle pipe_enable pulses, cycle_count=3, state=IDLE.
- Load with N=0 streamed back-to-back (1024 bytes) → 256 writes, last at addr 255, no dropped bytes.
- Reset asserted after 2 of 4 data bytes → no imem_we, state=IDLE, imem_addr=0.

Source files
------------

// File: rtl/debug_run_controller.sv
// Host-driven sequencer for the MIPS_DLX pipeline: loads instruction memory from
// a byte stream, then runs free or single-steps the pipeline until a halt retires.
module debug_run_controller #(
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter int unsigned ADDR_W    = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              wb_halt,
   output logic              pipe_enable,
   output logic              pipe_reset,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [31:0]       cycle_count,
   output logic [2:0]        state,
   output logic              done
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LD_CNT  = 3'd1;
   localparam logic [2:0] LD_DATA = 3'd2;
   localparam logic [2:0] RUN     = 3'd3;
   localparam logic [2:0] STEP    = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   localparam logic [7:0] CMD_LOAD  = 8'h4C;
   localparam logic [7:0] CMD_RUN   = 8'h52;
   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [7:0] CMD_QUIT  = 8'h51;
   localparam logic [7:0] CMD_TICK  = 8'h73;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic [1:0] byte_idx;
   logic [8:0] words_left;

   logic cmd_quit;
   logic cmd_tick;
   logic halt_seen;
   logic step_halt;

   assign cmd_quit  = rx_valid && (rx_data == CMD_QUIT);
   assign cmd_tick  = rx_valid && (rx_data == CMD_TICK);
   // wb_halt still reflects the old pipeline contents while pipe_reset is high
   assign halt_seen = wb_halt && !pipe_reset;
   assign step_halt = halt_seen && (pipe_enable || cmd_tick);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         pipe_enable <= 1'b0;
         pipe_reset  <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         cycle_count <= '0;
         done        <= 1'b0;
         byte_idx    <= '0;
         words_left  <= '0;
      end else begin
         imem_we    <= 1'b0;
         pipe_reset <= 1'b0;

         if (imem_we)
            imem_addr <= imem_addr + ADDR_ONE;

         if (pipe_enable && (cycle_count != '1))
            cycle_count <= cycle_count + 32'd1;

         case (state)
            IDLE: begin
               pipe_enable <= 1'b0;
               if (rx_valid) begin
                  if (rx_data == CMD_LOAD) begin
                     state <= LD_CNT;
                  end else if (rx_data == CMD_RUN) begin
                     state       <= RUN;
                     pipe_reset  <= 1'b1;
                     cycle_count <= '0;
                  end else if (rx_data == CMD_STEP) begin
                     state       <= STEP;
                     pipe_reset  <= 1'b1;
                     cycle_count <= '0;
                  end
               end
            end

            LD_CNT: begin
               if (rx_valid) begin
                  words_left <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                  imem_addr  <= '0;
                  byte_idx   <= '0;
                  state      <= LD_DATA;
               end
            end

            LD_DATA: begin
               if (rx_valid) begin
                  imem_wdata <= {imem_wdata[23:0], rx_data};
                  byte_idx   <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     imem_we    <= 1'b1;
                     words_left <= words_left - 9'd1;
                     if (words_left == 9'd1)
                        state <= IDLE;
                  end
               end
            end

            RUN: begin
               // the cycle that samples the halt was enabled; it is counted above
               if (halt_seen || cmd_quit) begin
                  state       <= DONE;
                  pipe_enable <= 1'b0;
                  done        <= 1'b1;
               end else begin
                  pipe_enable <= 1'b1;
               end
            end

            STEP: begin
               pipe_enable <= 1'b0;
               if (step_halt) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (cmd_quit) begin
                  state <= IDLE;
               end else if (cmd_tick) begin
                  pipe_enable <= 1'b1;
               end
            end

            DONE: begin
               pipe_enable <= 1'b0;
               if (rx_valid) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end

            default: begin
               state       <= IDLE;
               pipe_enable <= 1'b0;
               done        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed bench for debug_run_controller: reset, load, run-to-halt, single step,
// full 256-word load and reset during a load, all against hand-computed values.
module tb_debug_run_controller;

   localparam int unsigned ADDR_W = 10;

   logic              clock;
   logic              reset;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              wb_halt;
   logic              pipe_enable;
   logic              pipe_reset;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [31:0]       cycle_count;
   logic [2:0]        state;
   logic              done;

   debug_run_controller #(
      .HALT_WORD (32'hFFFF_FFFF),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .wb_halt     (wb_halt),
      .pipe_enable (pipe_enable),
      .pipe_reset  (pipe_reset),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .cycle_count (cycle_count),
      .state       (state),
      .done        (done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Strobe/pulse bookkeeping, sampled mid-cycle on the falling edge
   int   we_cnt   = 0;
   int   rst_cnt  = 0;
   int   en_rise  = 0;
   int   overlap  = 0;
   logic pe_q     = 1'b0;
   logic [ADDR_W-1:0] log_addr[$];
   logic [31:0]       log_data[$];

   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         we_cnt++;
         log_addr.push_back(imem_addr);
         log_data.push_back(imem_wdata);
      end
      if (pipe_reset === 1'b1) rst_cnt++;
      if (pipe_enable === 1'b1 && pe_q !== 1'b1) en_rise++;
      if (pipe_enable === 1'b1 && pipe_reset === 1'b1) overlap++;
      pe_q = pipe_enable;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   function automatic logic [7:0] bval(input int j);
      return 8'((j * 7 + 3) & 255);
   endfunction

   int base_we, base_rst, base_rise, base_log, bad;
   logic [31:0] expw;

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h4C;
      wb_halt  = 1'b0;
      tick();
      tick();

      // reset with rx_valid active
      check("rst_state", 32'(state), 32'd0);
      check("rst_pe", 32'(pipe_enable), 32'd0);
      check("rst_prst", 32'(pipe_reset), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_cc", cycle_count, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset    = 1'b0;
      rx_valid = 1'b0;
      tick();
      send(8'h58);
      check("idle_ignore", 32'(state), 32'd0);

      // two-word load
      base_we  = we_cnt;
      base_log = log_addr.size();
      send(8'h4C);
      check("ld_cnt_state", 32'(state), 32'd1);
      send(8'h02);
      check("ld_data_state", 32'(state), 32'd2);
      check("ld_addr0", 32'(imem_addr), 32'd0);
      send(8'h12); send(8'h34); send(8'h56); send(8'h78);
      check("ld_we0", 32'(imem_we), 32'd1);
      check("ld_waddr0", 32'(imem_addr), 32'd0);
      check("ld_wdata0", imem_wdata, 32'h12345678);
      send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0);
      check("ld_we1", 32'(imem_we), 32'd1);
      check("ld_waddr1", 32'(imem_addr), 32'd1);
      check("ld_wdata1", imem_wdata, 32'h9ABCDEF0);
      check("ld_end_state", 32'(state), 32'd0);
      tick();
      check("ld_we_count", 32'(we_cnt - base_we), 32'd2);
      check("ld_we_idle", 32'(imem_we), 32'd0);
      check("ld_log_addr1", 32'(log_addr[base_log + 1]), 32'd1);

      // run until halt
      base_rst = rst_cnt;
      send(8'h52);
      check("run_prst", 32'(pipe_reset), 32'd1);
      check("run_pe_k1", 32'(pipe_enable), 32'd0);
      check("run_state", 32'(state), 32'd3);
      tick();
      check("run_pe_k2", 32'(pipe_enable), 32'd1);
      check("run_prst_k2", 32'(pipe_reset), 32'd0);
      repeat (20) tick();
      check("run_cc_mid", cycle_count, 32'd20);
      wb_halt = 1'b1;
      tick();
      wb_halt = 1'b0;
      check("halt_done", 32'(done), 32'd1);
      check("halt_pe", 32'(pipe_enable), 32'd0);
      check("halt_state", 32'(state), 32'd5);
      check("halt_cc", cycle_count, 32'd21);
      repeat (3) tick();
      check("done_cc_hold", cycle_count, 32'd21);
      check("run_rst_pulses", 32'(rst_cnt - base_rst), 32'd1);
      send(8'h00);
      check("done_exit", 32'(state), 32'd0);
      check("done_clr", 32'(done), 32'd0);

      // run: stray bytes dropped, 'Q' forces DONE
      send(8'h52);
      tick();
      send(8'h4C);
      check("run_drop", 32'(state), 32'd3);
      send(8'h51);
      check("runq_state", 32'(state), 32'd5);
      check("runq_cc", cycle_count, 32'd2);
      send(8'h20);

      // single step
      base_rise = en_rise;
      send(8'h53);
      check("step_prst", 32'(pipe_reset), 32'd1);
      check("step_state", 32'(state), 32'd4);
      for (int i = 0; i < 3; i++) begin
         repeat (4) tick();
         send(8'h73);
         check("step_pe_on", 32'(pipe_enable), 32'd1);
         tick();
         check("step_pe_off", 32'(pipe_enable), 32'd0);
      end
      send(8'h51);
      check("step_q_state", 32'(state), 32'd0);
      check("step_cc", cycle_count, 32'd3);
      check("step_pulses", 32'(en_rise - base_rise), 32'd3);

      // simultaneous step and halt: halt wins, no pulse
      send(8'h53);
      tick();
      wb_halt = 1'b1;
      send(8'h73);
      wb_halt = 1'b0;
      check("sh_state", 32'(state), 32'd5);
      check("sh_pe", 32'(pipe_enable), 32'd0);
      check("sh_done", 32'(done), 32'd1);
      check("sh_cc", cycle_count, 32'd0);
      send(8'h00);

      // 256-word load streamed back-to-back
      base_we  = we_cnt;
      base_log = log_addr.size();
      send(8'h4C);
      send(8'h00);
      for (int j = 0; j < 1024; j++) begin
         rx_data  = bval(j);
         rx_valid = 1'b1;
         tick();
      end
      rx_valid = 1'b0;
      check("big_last_we", 32'(imem_we), 32'd1);
      check("big_last_addr", 32'(imem_addr), 32'd255);
      check("big_last_data", imem_wdata, {bval(1020), bval(1021), bval(1022), bval(1023)});
      check("big_state", 32'(state), 32'd0);
      tick();
      check("big_we_count", 32'(we_cnt - base_we), 32'd256);
      bad = 0;
      for (int w = 0; w < 256; w++) begin
         expw = {bval(4 * w), bval(4 * w + 1), bval(4 * w + 2), bval(4 * w + 3)};
         if (log_addr[base_log + w] !== ADDR_W'(w) || log_data[base_log + w] !== expw) bad++;
      end
      check("big_contents", 32'(bad), 32'd0);

      // reset during a load
      base_we = we_cnt;
      send(8'h4C);
      send(8'h01);
      send(8'hAA);
      send(8'hBB);
      reset    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hCC;
      tick();
      rx_data  = 8'hDD;
      tick();
      reset    = 1'b0;
      rx_valid = 1'b0;
      send(8'h11);
      send(8'h22);
      tick();
      check("mid_rst_we", 32'(we_cnt - base_we), 32'd0);
      check("mid_rst_state", 32'(state), 32'd0);
      check("mid_rst_addr", 32'(imem_addr), 32'd0);
      check("mid_rst_wdata", imem_wdata, 32'd0);

      check("no_overlap", 32'(overlap), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
